vga_scan_gen: RTL and testbench
===============================

// Module: vga_scan_gen
// PURPOSE
// - Upstream raster stage for the pixel-address converter. Generates 640x480@60 VGA timing.
// - Drives pos_x/pos_y and CHG_IMG to the address stage, and hsync/vsync/video_on to the DAC.
// - Latches user image-change requests and applies them only at a frame boundary, so no frame tears.
// PARAMETERS
// - H_ACTIVE 640 : visible pixels per line
// - H_FP 16 : horizontal front porch
// - H_SYNC 96 : horizontal sync width
// - H_BP 48 : horizontal back porch
// - V_ACTIVE 480 : visible lines
// - V_FP 10 : vertical front porch
// - V_SYNC 2 : vertical sync width
// - V_BP 33 : vertical back porch
// - DIV 2 : system clocks per pixel (50 MHz -> 25 MHz); must be >= 1
// - ALIGN_DLY 2 : pixel ticks of sync/video_on delay when SYNC_ALIGN_EN is defined
// PORTS
// - clk       in   1   system clock
// - rst_n     in   1   asynchronous active-low reset
// - chg_req   in   1   asynchronous image-change button, active high
// - pix_tick  out  1   one-clk strobe per pixel; counters advance only on it
// - pos_x     out  10  column, 0..H_ACTIVE-1 when video_on, else 0
// - pos_y     out  10  row, 0..V_ACTIVE-1 when video_on, else 0
// - CHG_IMG   out  1   selected image; toggles only at frame start
// - hsync     out  1   horizontal sync, active low
// - vsync     out  1   vertical sync, active low
// - video_on  out  1   high inside the active area
// - frame_start out 1  one-clk pulse on the tick where counters wrap to (0,0)
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - div_cnt, h_cnt, v_cnt = 0; pix_tick = 0; pos_x = pos_y = 0.
//   - hsync = vsync = 1; video_on = 1; CHG_IMG = 0; pending = 0; frame_start = 0.
// - Reset mid-frame: same values immediately, with no completion of the line.
// - Pixel divider:
//   - div_cnt counts 0..DIV-1. pix_tick = 1 for the clk cycle where div_cnt == DIV-1.
//   - With DIV = 1, pix_tick is constantly 1 after reset.
// - Horizontal counter: H_TOTAL = 800. On pix_tick, h_cnt wraps from 799 to 0; otherwise it increments.
// - Vertical counter: V_TOTAL = 525. v_cnt advances only on a pix_tick where h_cnt == 799, and wraps from 524 to 0.
// - Registered outputs (hsync, vsync, video_on, pos_x, pos_y):
//   - Decoded from the next counter values, so they align with h_cnt/v_cnt in the same cycle.
//   - hsync = 0 for h in [656,752); vsync = 0 for v in [490,492).
//   - video_on = (h < 640) && (v < 480).
// - frame_start = 1 for one clk on the tick where (h,v) goes (799,524) -> (0,0). It does not pulse on reset exit.
// - Image change:
//   - chg_req passes a 2-FF synchronizer and rising-edge detector; an edge sets pending.
//   - On frame_start: if pending = 1, CHG_IMG toggles and pending clears.
//   - An edge in the same cycle as frame_start is kept pending and applied at the next frame.
//   - Multiple edges within one frame produce a single toggle.
// CONFIGURATION
// - SYNC_ALIGN_EN defined:
//   - hsync, vsync and video_on pass through an ALIGN_DLY-stage shift register clocked on pix_tick.
//   - This covers address-stage plus memory read latency.
//   - pos_x, pos_y, CHG_IMG and frame_start are not delayed.
//   - Stage reset values: 1, 1, 0.
// - SYNC_ALIGN_EN undefined: sync and video_on are aligned with the counters (zero delay).
// STRUCTURE
// - Shared package vga_pkg:
//   - typedef logic [9:0] coord_t.
//   - Default timing constants.
//   - Localparams H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END.
// - Sub-module sync_edge_det: 2-FF synchronizer plus rising-edge pulse, reset to 0. It is instantiated once, for chg_req.
// TESTING
// - Reset, DIV=2: release rst_n -> pix_tick every 2nd clk; pos=(0,0), hsync=1, vsync=1, video_on=1.
// - Line timing: run 800 ticks -> hsync low exactly at h=656..751; video_on falls at h=640; v increments at the 799->0 wrap.
// - Frame timing: run 420000 ticks -> vsync low only at v=490..491; frame_start every 800*525 ticks.
// - Image change: pulse chg_req at (100,50) -> CHG_IMG stays 0 until the next frame_start, then becomes 1. Two pulses in one frame -> one toggle.
// - Boundary: chg_req edge on the frame_start cycle -> CHG_IMG toggles one frame later. Assert rst_n=0 at (300,200) -> all outputs at reset values at once.
// - SYNC_ALIGN_EN, ALIGN_DLY=2: hsync falls 2 ticks after h=656 while pos_x is unchanged.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster stage.
// Optional SYNC_ALIGN_EN delays sync/video_on by ALIGN_DLY pixel ticks.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_ACTIVE_D  = 640;
  localparam int H_FP_D      = 16;
  localparam int H_SYNC_D    = 96;
  localparam int H_BP_D      = 48;
  localparam int V_ACTIVE_D  = 480;
  localparam int V_FP_D      = 10;
  localparam int V_SYNC_D    = 2;
  localparam int V_BP_D      = 33;
  localparam int DIV_D       = 2;
  localparam int ALIGN_DLY_D = 2;

  localparam int H_TOTAL  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
  localparam int HS_START = H_ACTIVE_D + H_FP_D;
  localparam int HS_END   = HS_START + H_SYNC_D;
  localparam int VS_START = V_ACTIVE_D + V_FP_D;
  localparam int VS_END   = VS_START + V_SYNC_D;

  function automatic logic in_win(
    input coord_t val,
    input coord_t lo,
    input coord_t hi
  );
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input followed by a
// registered one-clock rising-edge pulse.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
      rise <= sync & ~prev;
    end
  end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster generator: pixel divider, h/v counters, sync decode and
// frame-synchronous image select. SYNC_ALIGN_EN adds sync/video delay.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int DIV      = DIV_D
`ifdef SYNC_ALIGN_EN
  ,
  parameter int ALIGN_DLY = ALIGN_DLY_D
`endif
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   chg_req,
  output logic   pix_tick,
  output coord_t pos_x,
  output coord_t pos_y,
  output logic   CHG_IMG,
  output logic   hsync,
  output logic   vsync,
  output logic   video_on,
  output logic   frame_start
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  localparam coord_t H_LAST = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_ACT  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT  = coord_t'(V_ACTIVE);
  localparam coord_t HS_BEG = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_FIN = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_BEG = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_FIN = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  coord_t        h_cnt;
  coord_t        v_cnt;
  coord_t        h_nxt;
  coord_t        v_nxt;
  logic          wrap;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          vo_nxt;
  logic          hs_r;
  logic          vs_r;
  logic          vo_r;
  logic          chg_rise;
  logic          pending;

  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  end

  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    wrap  = 1'b0;
    if (pix_tick) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        if (v_cnt == V_LAST) begin
          v_nxt = '0;
          wrap  = 1'b1;
        end else begin
          v_nxt = v_cnt + 1'b1;
        end
      end else begin
        h_nxt = h_cnt + 1'b1;
      end
    end
  end

  // Decode from next counts so registered outputs line up with h_cnt/v_cnt
  always_comb begin
    hs_nxt = ~in_win(h_nxt, HS_BEG, HS_FIN);
    vs_nxt = ~in_win(v_nxt, VS_BEG, VS_FIN);
    vo_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      pix_tick    <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      pos_x       <= '0;
      pos_y       <= '0;
      hs_r        <= 1'b1;
      vs_r        <= 1'b1;
      vo_r        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      pix_tick    <= (div_nxt == DIV_LAST);
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      pos_x       <= vo_nxt ? h_nxt : '0;
      pos_y       <= vo_nxt ? v_nxt : '0;
      hs_r        <= hs_nxt;
      vs_r        <= vs_nxt;
      vo_r        <= vo_nxt;
      frame_start <= wrap;
    end
  end

  sync_edge_det u_chg_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (chg_req),
    .rise  (chg_rise)
  );

  // A request landing on the swap itself stays queued for the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CHG_IMG <= 1'b0;
      pending <= 1'b0;
    end else if (wrap && pending) begin
      CHG_IMG <= ~CHG_IMG;
      pending <= chg_rise;
    end else if (chg_rise) begin
      pending <= 1'b1;
    end
  end

`ifdef SYNC_ALIGN_EN
  logic [ALIGN_DLY-1:0] hs_pipe;
  logic [ALIGN_DLY-1:0] vs_pipe;
  logic [ALIGN_DLY-1:0] vo_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
      vo_pipe <= '0;
    end else if (pix_tick) begin
      hs_pipe[0] <= hs_r;
      vs_pipe[0] <= vs_r;
      vo_pipe[0] <= vo_r;
      for (int i = 1; i < ALIGN_DLY; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
        vo_pipe[i] <= vo_pipe[i-1];
      end
    end
  end

  assign hsync    = hs_pipe[ALIGN_DLY-1];
  assign vsync    = vs_pipe[ALIGN_DLY-1];
  assign video_on = vo_pipe[ALIGN_DLY-1];
`else
  assign hsync    = hs_r;
  assign vsync    = vs_r;
  assign video_on = vo_r;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen: full 800-pixel lines, shortened
// 8-line frames (V 4/1/2/1), DIV=2 so one tick per two clocks.
module tb_vga_scan_gen;

  localparam int HT = 800;
  localparam int VT = 8;
  localparam int FT = HT * VT;
`ifdef SYNC_ALIGN_EN
  localparam int AD = 2;
`else
  localparam int AD = 0;
`endif
  localparam logic VO_RST = (AD == 0);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       chg_req;
  logic       pix_tick;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       CHG_IMG;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;

  int k;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic vo;
    int   px;
    int   py;
  } vec_t;

  vec_t vecs [15];

  vga_scan_gen #(
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (1),
    .DIV      (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .chg_req     (chg_req),
    .pix_tick    (pix_tick),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .CHG_IMG     (CHG_IMG),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic goto_k(input int t);
    while (k < t) begin
      @(posedge clk);
      k++;
      #1;
    end
  endtask

  task automatic go(input int h, input int v, input int f);
    goto_k(2 * (f * FT + v * HT + h));
  endtask

  task automatic pulse_chg();
    chg_req = 1'b1;
    goto_k(k + 4);
    chg_req = 1'b0;
  endtask

  function automatic logic [31:0] rst_vec();
    return {24'd0, pix_tick, hsync, vsync, video_on,
            CHG_IMG, frame_start, |pos_x, |pos_y};
  endfunction

  initial begin
    int bad;
    logic [31:0] exp_rst;
    exp_rst = {24'd0, 1'b0, 1'b1, 1'b1, VO_RST, 4'b0000};

    vecs = '{
      '{1,   0, 1'b1, 1'b1, 1'b1, 1,   0},
      '{639, 0, 1'b1, 1'b1, 1'b1, 639, 0},
      '{640, 0, 1'b1, 1'b1, 1'b0, 0,   0},
      '{655, 0, 1'b1, 1'b1, 1'b0, 0,   0},
      '{656, 0, 1'b0, 1'b1, 1'b0, 0,   0},
      '{751, 0, 1'b0, 1'b1, 1'b0, 0,   0},
      '{752, 0, 1'b1, 1'b1, 1'b0, 0,   0},
      '{799, 0, 1'b1, 1'b1, 1'b0, 0,   0},
      '{0,   1, 1'b1, 1'b1, 1'b1, 0,   1},
      '{10,  3, 1'b1, 1'b1, 1'b1, 10,  3},
      '{10,  4, 1'b1, 1'b1, 1'b0, 0,   0},
      '{0,   5, 1'b1, 1'b0, 1'b0, 0,   0},
      '{700, 6, 1'b0, 1'b0, 1'b0, 0,   0},
      '{0,   7, 1'b1, 1'b1, 1'b0, 0,   0},
      '{799, 7, 1'b1, 1'b1, 1'b0, 0,   0}
    };

    rst_n   = 1'b0;
    chg_req = 1'b0;
    k       = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", rst_vec(), exp_rst);

    @(negedge clk);
    rst_n = 1'b1;
    k     = 0;
    #1;
    chk("reset_exit", rst_vec(), exp_rst);
    goto_k(1);
    chk("tick_k1", {31'd0, pix_tick}, 32'd1);
    goto_k(2);
    chk("tick_k2", {30'd0, pix_tick, frame_start}, 32'd0);
    goto_k(3);
    chk("tick_k3", {31'd0, pix_tick}, 32'd1);

    for (int i = 0; i < 15; i++) begin
      go(vecs[i].h, vecs[i].v, 0);
`ifdef SYNC_ALIGN_EN
      chk($sformatf("vec%0d", i), {12'd0, pos_x, pos_y},
          {12'd0, 10'(vecs[i].px), 10'(vecs[i].py)});
`else
      chk($sformatf("vec%0d", i),
          {9'd0, hsync, vsync, video_on, pos_x, pos_y},
          {9'd0, vecs[i].hs, vecs[i].vs, vecs[i].vo,
           10'(vecs[i].px), 10'(vecs[i].py)});
`endif
    end
    chk("fs_before_wrap", {31'd0, frame_start}, 32'd0);

    go(0, 0, 1);
    chk("fs_wrap", {11'd0, frame_start, pos_x, pos_y},
        {11'd0, 1'b1, 20'd0});
    goto_k(k + 1);
    chk("fs_one_clk", {30'd0, frame_start, pix_tick}, 32'd1);

    go(100, 2, 1);
    chk("chg_before", {31'd0, CHG_IMG}, 32'd0);
    pulse_chg();

    bad = 0;
    for (int h = 0; h < HT; h++) begin
      go(h, 3, 1);
      if (hsync !== !(h >= 656 + AD && h < 752 + AD)) bad++;
      if (video_on !== (h >= AD && h < 640 + AD)) bad++;
      if (pos_x !== ((h < 640) ? 10'(h) : 10'd0)) bad++;
      if (pos_y !== ((h < 640) ? 10'd3 : 10'd0)) bad++;
    end
    chk("line_sweep", bad, 0);

    go(799, 7, 1);
    chk("chg_held", {31'd0, CHG_IMG}, 32'd0);
    go(0, 0, 2);
    chk("chg_applied", {30'd0, frame_start, CHG_IMG}, 32'd3);

    go(100, 1, 2);
    pulse_chg();
    go(300, 3, 2);
    pulse_chg();
    go(799, 7, 2);
    chk("chg2_held", {31'd0, CHG_IMG}, 32'd1);
    go(0, 0, 3);
    chk("chg2_single", {30'd0, frame_start, CHG_IMG}, 32'd2);
    go(0, 0, 4);
    chk("chg2_no_retoggle", {31'd0, CHG_IMG}, 32'd0);

    goto_k(2 * 4 * FT - 3);
    chk("chg3_pre", {31'd0, CHG_IMG}, 32'd0);
    chg_req = 1'b1;
    goto_k(2 * 4 * FT);
    chk("chg3_fs", {30'd0, frame_start, CHG_IMG}, 32'd2);
    goto_k(k + 3);
    chg_req = 1'b0;
    go(799, 7, 4);
    chk("chg3_held", {31'd0, CHG_IMG}, 32'd0);
    go(0, 0, 5);
    chk("chg3_applied", {30'd0, frame_start, CHG_IMG}, 32'd3);

    go(300, 2, 5);
    chk("mid_pos", {12'd0, pos_x, pos_y}, {12'd0, 10'd300, 10'd2});
    rst_n = 1'b0;
    #1;
    chk("mid_reset", rst_vec(), exp_rst);
    @(negedge clk);
    rst_n = 1'b1;
    k     = 0;
    #1;
    chk("mid_exit", rst_vec(), exp_rst);
    go(1, 0, 0);
    chk("mid_restart", {11'd0, CHG_IMG, pos_x, pos_y},
        {11'd0, 1'b0, 10'd1, 10'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
